dec_xfm_dequant: RTL and testbench
==================================

# dec_xfm_dequant

Downstream stage of the transform-mode coefficient decode. It accepts one 8x2 block of 16 reordered, entropy-decoded coefficients per handshake, together with the block QP. It dequantizes each coefficient with a QP-indexed scale and shift, saturates the result, and streams the results one coefficient per beat, in raster order, to the inverse-transform stage. Blocks not coded in transform mode are consumed without producing output.

## Interface
- `ssm_idx`, default 0: substream index. Identification only; no functional effect.
- `comp`, default 0: component index. Identification only; no functional effect.
- `OUT_W`, default 16: width of the dequantized output coefficient, two's complement.

Ports (clock and reset first):
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: block presented on the input.
- `in_ready` out 1: block accepted when `in_valid` and `in_ready` are both high at a rising edge of `clk`.
- `mode_XFM` in 1: 1 means a transform block; 0 means the block is dropped.
- `qp` in 6: block QP, 0..63.
- `coeff_in` in 144: coefficient i occupies `[9i+8:9i]`; 9-bit two's complement; i is the raster position 0..15 after reordering.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: output beat accepted when `out_valid` and `out_ready` are both high at a rising edge.
- `out_coef` out `OUT_W`: dequantized coefficient.
- `out_pos` out 4: raster position of `out_coef`.
- `out_last` out 1: high on the beat where `out_pos` is 15.
- `out_sat` out 1: the current beat was saturated.

## Operation
- Scale table, indexed by `qp[2:0]`: S = {16, 18, 20, 22, 23, 25, 27, 29}.
- Arithmetic for each coefficient c (signed 9 bits):
  - p = c * S[qp[2:0]], 14-bit signed.
  - v = p << qp[5:3], 21-bit signed.
  - `out_coef` = v clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - `out_sat` = 1 when the clamp changed the value.
- Capture registers hold 16×9 coefficient bits and `qp`. They load only on an input handshake where `mode_XFM` = 1.
- State machine:
  - IDLE:
    - `in_ready` = 1 and `out_valid` = 0.
    - Handshake with `mode_XFM` = 1: capture the block, set the position counter to 0, go to RUN.
    - Handshake with `mode_XFM` = 0: drop the block and stay in IDLE. No output and no register update.
  - RUN:
    - `out_valid` = 1, `out_pos` = counter, and `out_coef`/`out_sat` are computed from the captured coefficient at index counter.
    - Each output handshake increments the counter.
    - Handshake with counter = 15 (`out_last` = 1): the counter wraps to 0 and the state goes to IDLE, unless an input is accepted in the same cycle (next bullet).
  - Back-to-back blocks: in RUN, `in_ready` = `out_ready` AND (counter == 15). This is the only combinational input-to-output path.
    - Input handshake with `mode_XFM` = 1 in that cycle: capture the new block and stay in RUN with counter 0. Zero bubbles between blocks.
    - Input handshake with `mode_XFM` = 0 in that cycle: drop it and go to IDLE.
- While `out_ready` = 0 in RUN:
  - `out_coef`, `out_pos`, `out_last` and `out_sat` hold.
  - `in_ready` = 0.
- Reset (asynchronous, at any time including mid-block):
  - State = IDLE, counter = 0, capture registers = 0.
  - `out_valid` = 0, `out_coef` = 0, `out_pos` = 0, `out_last` = 0, `out_sat` = 0, `in_ready` = 1 once the state is IDLE.
  - A partially streamed block is discarded; nothing resumes after reset.
- `out_coef`/`out_sat` are combinational from registered state only (capture registers and counter). They are 0 when `out_valid` = 0.

## Timing
- Input accepted at edge T: first beat (`out_pos` = 0) valid from T+1.
- With `out_ready` held high, the beat at `out_pos` = k is transferred at edge T+1+k. The last beat is transferred at T+16.
- Sustained throughput: one block per 16 cycles, one coefficient per cycle.
- Dropped (`mode_XFM` = 0) block: one cycle of `in_ready` only; no output activity.
- Changing the `coeff_in`/`qp` inputs while in RUN has no effect on output until the next capture.

## Test plan
- Single block, `out_ready` = 1, `qp` = 10, c0 = 5, c1 = -3, others 0:
  - beat 0 = 200 (5 × 20 × 2), beat 1 = -120;
  - beats 2..15 = 0;
  - `out_last` only on beat 15; `out_valid` spans exactly 16 cycles starting T+1.
- Saturation, `qp` = 63:
  - c0 = -256 → `out_coef` = -32768, `out_sat` = 1;
  - c1 = 255 → 32767, `out_sat` = 1;
  - `qp` = 0, c = -3 → -48, `out_sat` = 0.
- Backpressure: toggle `out_ready` pseudo-randomly → every position 0..15 is delivered exactly once and in order; outputs hold while stalled; `in_ready` = 0 throughout.
- Back-to-back: two blocks, second `in_valid` held high, `out_ready` = 1 → 32 consecutive valid beats with no bubble; the second block's `qp` is applied from its beat 0.
- Drop path:
  - `mode_XFM` = 0 block in IDLE → consumed in 1 cycle, no `out_valid`.
  - `mode_XFM` = 0 block presented on the last-beat cycle → consumed, state goes to IDLE.
- Reset mid-block: assert `rst_n` = 0 at beat 7 → all outputs 0 immediately and `in_ready` = 1. After release, a new block streams from `out_pos` = 0 with no residue of the old block.

Source files
------------

// File: rtl/dec_xfm_dequant.sv
// rtl/dec_xfm_dequant.sv - dequantizes a captured 8x2 coefficient block and streams it one coefficient per beat
module dec_xfm_dequant #(
  parameter int ssm_idx = 0,
  parameter int comp    = 0,
  parameter int OUT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode_XFM,
  input  logic [5:0]         qp,
  input  logic [143:0]       coeff_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_coef,
  output logic [3:0]         out_pos,
  output logic               out_last,
  output logic               out_sat
);

  typedef enum logic {IDLE, RUN} state_e;

  // Clamp bounds live in a 22-bit domain so OUT_W up to 21 never wraps the limits.
  localparam logic signed [21:0] MAX_V = (22'sd1 <<< (OUT_W - 1)) - 22'sd1;
  localparam logic signed [21:0] MIN_V = -MAX_V - 22'sd1;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [15:0][8:0]        coef_q;
  logic [5:0]              qp_q;

  logic                    at_last;
  logic                    in_hs;
  logic                    out_hs;
  logic                    unused_params;

  assign unused_params = ^{ssm_idx, comp};

  assign at_last   = (state_q == RUN) && (cnt_q == 4'd15);
  assign out_valid = (state_q == RUN);
  assign in_ready  = (state_q == IDLE) || (out_ready && at_last);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      coef_q  <= '0;
      qp_q    <= 6'd0;
    end else if (state_q == IDLE) begin
      if (in_hs && mode_XFM) begin
        coef_q  <= coeff_in;
        qp_q    <= qp;
        cnt_q   <= 4'd0;
        state_q <= RUN;
      end
    end else if (out_hs) begin
      if (cnt_q == 4'd15) begin
        cnt_q <= 4'd0;
        // An input can only be accepted on the last beat, which keeps blocks bubble-free.
        if (in_hs && mode_XFM) begin
          coef_q <= coeff_in;
          qp_q   <= qp;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  logic [4:0]              scale;
  logic signed [8:0]       c_sel;
  logic signed [13:0]      c_ext;
  logic signed [13:0]      s_ext;
  logic signed [13:0]      prod;
  logic signed [21:0]      shifted;
  logic                    sat_hi;
  logic                    sat_lo;

  always_comb begin
    scale = 5'd16;
    case (qp_q[2:0])
      3'd0: scale = 5'd16;
      3'd1: scale = 5'd18;
      3'd2: scale = 5'd20;
      3'd3: scale = 5'd22;
      3'd4: scale = 5'd23;
      3'd5: scale = 5'd25;
      3'd6: scale = 5'd27;
      3'd7: scale = 5'd29;
      default: scale = 5'd16;
    endcase
  end

  assign c_sel   = coef_q[cnt_q];
  assign c_ext   = {{5{c_sel[8]}}, c_sel};
  assign s_ext   = {9'd0, scale};
  assign prod    = c_ext * s_ext;
  assign shifted = {{8{prod[13]}}, prod} <<< qp_q[5:3];
  assign sat_hi  = shifted > MAX_V;
  assign sat_lo  = shifted < MIN_V;

  always_comb begin
    out_coef = '0;
    if (out_valid) begin
      if (sat_hi)      out_coef = MAX_V[OUT_W-1:0];
      else if (sat_lo) out_coef = MIN_V[OUT_W-1:0];
      else             out_coef = shifted[OUT_W-1:0];
    end
  end

  assign out_sat  = out_valid && (sat_hi || sat_lo);
  assign out_pos  = cnt_q;
  assign out_last = at_last;

endmodule

// File: tb/tb_dec_xfm_dequant.sv
// tb/tb_dec_xfm_dequant.sv - randomized self-checking bench with a beat-queue reference model
module tb_dec_xfm_dequant;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         mode_XFM = 1'b0;
  logic [5:0]   qp = 6'd0;
  logic [143:0] coeff_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [15:0]  out_coef;
  logic [3:0]   out_pos;
  logic         out_last;
  logic         out_sat;

  always #5 clk = ~clk;

  dec_xfm_dequant #(.ssm_idx(0), .comp(0), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode_XFM(mode_XFM), .qp(qp), .coeff_in(coeff_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_pos(out_pos), .out_last(out_last), .out_sat(out_sat)
  );

  typedef struct {int coef; int sat; int pos;} beat_t;
  beat_t exp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int c0;
  bit rnd_rdy = 1'b0;
  bit last_in_hs = 1'b0;
  logic [143:0] blk;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  function automatic void dq(input int c, input int q, output int v, output int s);
    int sc [8] = '{16, 18, 20, 22, 23, 25, 27, 29};
    int p;
    p = c * sc[q % 8] * (1 << (q / 8));
    v = p;
    s = 0;
    if (p > 32767) begin v = 32767; s = 1; end
    else if (p < -32768) begin v = -32768; s = 1; end
  endfunction

  task automatic cycle();
    bit exp_ir, ohs, ihs, cur_mode;
    logic [5:0] cur_qp;
    logic [143:0] cur_blk;
    beat_t b;
    @(negedge clk);
    exp_ir = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
    check("out_valid", out_valid, int'(exp_q.size() > 0));
    check("in_ready", in_ready, exp_ir);
    if (exp_q.size() > 0) begin
      check("out_coef", $signed(out_coef), exp_q[0].coef);
      check("out_sat", out_sat, exp_q[0].sat);
      check("out_pos", out_pos, exp_q[0].pos);
      check("out_last", out_last, int'(exp_q[0].pos == 15));
    end else begin
      check("idle_coef", $signed(out_coef), 0);
      check("idle_sat", out_sat, 0);
      check("idle_last", out_last, 0);
    end
    ohs = (exp_q.size() > 0) && out_ready;
    ihs = in_valid && exp_ir;
    cur_mode = mode_XFM;
    cur_qp = qp;
    cur_blk = coeff_in;
    @(posedge clk);
    cyc++;
    if (ohs) void'(exp_q.pop_front());
    if (ihs && cur_mode) begin
      for (int i = 0; i < 16; i++) begin
        dq(int'($signed(cur_blk[9*i +: 9])), int'(cur_qp), b.coef, b.sat);
        b.pos = i;
        exp_q.push_back(b);
      end
    end
    last_in_hs = ihs;
    #1;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < 16; i++) coeff_in[9*i +: 9] = 9'($urandom);
    qp = 6'($urandom);
  endtask

  task automatic send(input bit m, input logic [5:0] q, input logic [143:0] b);
    in_valid = 1'b1;
    mode_XFM = m;
    qp = q;
    coeff_in = b;
    last_in_hs = 1'b0;
    for (int k = 0; k < 100 && !last_in_hs; k++) cycle();
    if (!last_in_hs) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) cycle();
    if (exp_q.size() > 0) check("drain_timeout", int'(exp_q.size()), 0);
  endtask

  task automatic rand_blk();
    for (int i = 0; i < 16; i++) blk[9*i +: 9] = 9'($urandom);
  endtask

  initial begin
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_coef", $signed(out_coef), 0);
    check("rst_pos", out_pos, 0);
    check("rst_last", out_last, 0);
    check("rst_sat", out_sat, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    blk = '0; blk[8:0] = 9'(5); blk[17:9] = 9'(-3);
    send(1'b1, 6'd10, blk);
    c0 = cyc;
    check("t1_beat0", $signed(out_coef), 200);
    cycle();
    check("t1_beat1", $signed(out_coef), -120);
    drain();
    check("t1_len", cyc - c0, 16);

    blk = '0; blk[8:0] = 9'(-256); blk[17:9] = 9'(255);
    send(1'b1, 6'd63, blk);
    check("sat_neg", $signed(out_coef), -32768);
    check("sat_neg_flag", out_sat, 1);
    cycle();
    check("sat_pos", $signed(out_coef), 32767);
    check("sat_pos_flag", out_sat, 1);
    drain();
    blk = '0; blk[8:0] = 9'(-3);
    send(1'b1, 6'd0, blk);
    check("qp0_val", $signed(out_coef), -48);
    check("qp0_flag", out_sat, 0);
    drain();

    rnd_rdy = 1'b1;
    rand_blk();
    send(1'b1, 6'($urandom), blk);
    drain();
    rnd_rdy = 1'b0;
    cycle();

    rand_blk();
    send(1'b1, 6'd5, blk);
    c0 = cyc;
    blk = '0; blk[8:0] = 9'(7);
    send(1'b1, 6'd40, blk);
    check("b2b_gap", cyc - c0, 16);
    check("b2b_beat0", $signed(out_coef), 3584);
    drain();
    check("b2b_len", cyc - c0, 32);

    c0 = cyc;
    rand_blk();
    send(1'b0, 6'($urandom), blk);
    check("drop_idle_lat", cyc - c0, 1);
    cycle(); cycle();

    rand_blk();
    send(1'b1, 6'($urandom), blk);
    c0 = cyc;
    send(1'b0, 6'($urandom), blk);
    check("drop_last_lat", cyc - c0, 16);
    check("drop_last_idle", out_valid, 0);
    cycle();

    rand_blk();
    send(1'b1, 6'($urandom), blk);
    for (int k = 0; k < 7; k++) cycle();
    check("pre_rst_pos", out_pos, 7);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_coef", $signed(out_coef), 0);
    check("mrst_pos", out_pos, 0);
    check("mrst_last", out_last, 0);
    check("mrst_sat", out_sat, 0);
    check("mrst_in_ready", in_ready, 1);
    exp_q.delete();
    cycle(); cycle();
    rst_n = 1'b1;
    rand_blk();
    send(1'b1, 6'($urandom), blk);
    check("post_rst_pos", out_pos, 0);
    drain();

    rnd_rdy = 1'b1;
    for (int n = 0; n < 30; n++) begin
      rand_blk();
      send($urandom_range(0, 4) != 0, 6'($urandom), blk);
      if ($urandom_range(0, 2) == 0) cycle();
    end
    drain();
    rnd_rdy = 1'b0;
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
